// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: drives the next-PC mux select and PC load enable.
// It sequences the front-end flush after every redirect and latches
// interrupt requests until they can be taken in a clean RUN cycle.
module pc_redirect_ctrl #(
  parameter int FLUSH_CYCLES = 2,    // cycles FLUSH stays high per redirect (1..7)
  parameter bit INT_EN       = 1'b1  // 0 removes the interrupt entry path
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stall,
  input  logic       br_taken,
  input  logic       jal_ex,
  input  logic       jalr_ex,
  input  logic       mret_ex,
  input  logic       intr,
  input  logic       mie,
  output logic [2:0] pc_source,
  output logic       pc_write,
  output logic       flush,
  output logic       int_taken,
  output logic       int_pend
);

  typedef enum logic {RUN, FLUSHING} state_t;

  localparam logic [2:0] SRC_PC4    = 3'd0;
  localparam logic [2:0] SRC_JALR   = 3'd1;
  localparam logic [2:0] SRC_BRANCH = 3'd2;
  localparam logic [2:0] SRC_JAL    = 3'd3;
  localparam logic [2:0] SRC_MTVEC  = 3'd4;
  localparam logic [2:0] SRC_MEPC   = 3'd5;

  // Counter value loaded on a redirect: the redirect cycle itself is the
  // first flush cycle, so FLUSHING covers the remaining ones.
  localparam logic [2:0] FCNT_LOAD  = 3'(FLUSH_CYCLES - 1);

  state_t     state_reg;
  logic [2:0] fcnt_reg;
  logic       pend_reg;
  logic       redirect;

  // Zero-latency output decode from state, pending flag and EX inputs.
  always_comb begin
    pc_source = SRC_PC4;
    pc_write  = 1'b0;
    flush     = 1'b0;
    int_taken = 1'b0;
    redirect  = 1'b0;
    if (!rst) begin
      if (state_reg == FLUSHING) begin
        // EX resolutions here belong to squashed instructions: ignore them.
        flush    = 1'b1;
        pc_write = ~stall;
      end else if (mret_ex) begin
        pc_source = SRC_MEPC;
        pc_write  = 1'b1;
        flush     = 1'b1;
        redirect  = 1'b1;
      end else if (jalr_ex) begin
        pc_source = SRC_JALR;
        pc_write  = 1'b1;
        flush     = 1'b1;
        redirect  = 1'b1;
      end else if (br_taken) begin
        pc_source = SRC_BRANCH;
        pc_write  = 1'b1;
        flush     = 1'b1;
        redirect  = 1'b1;
      end else if (jal_ex) begin
        pc_source = SRC_JAL;
        pc_write  = 1'b1;
        flush     = 1'b1;
        redirect  = 1'b1;
      end else if ((INT_EN != 1'b0) && pend_reg && mie && !stall) begin
        // Interrupt entry only when no EX redirect competes and the
        // front end is not frozen.
        pc_source = SRC_MTVEC;
        pc_write  = 1'b1;
        flush     = 1'b1;
        int_taken = 1'b1;
        redirect  = 1'b1;
      end else if (stall) begin
        pc_write  = 1'b0;
      end else begin
        pc_write  = 1'b1;
      end
    end
  end

  assign int_pend = pend_reg;

  // Flush sequencer state, flush counter and interrupt pending flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= RUN;
      fcnt_reg  <= 3'd0;
      pend_reg  <= 1'b0;
    end else begin
      case (state_reg)
        RUN: begin
          if (redirect && (FLUSH_CYCLES > 1)) begin
            state_reg <= FLUSHING;
            fcnt_reg  <= FCNT_LOAD;
          end
        end
        FLUSHING: begin
          if (fcnt_reg == 3'd1) begin
            state_reg <= RUN;
            fcnt_reg  <= 3'd0;
          end else begin
            fcnt_reg  <= fcnt_reg - 3'd1;
          end
        end
        default: begin
          state_reg <= RUN;
          fcnt_reg  <= 3'd0;
        end
      endcase
      // Clearing on the taken cycle wins over a simultaneous new request.
      if (INT_EN == 1'b0) begin
        pend_reg <= 1'b0;
      end else if (int_taken) begin
        pend_reg <= 1'b0;
      end else if (intr) begin
        pend_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Scoreboard bench for pc_redirect_ctrl: the stimulus process pushes the
// hand-computed expected outputs for each cycle; a monitor pops and compares
// at the falling edge (or right after an asynchronous reset is applied).
module tb_pc_redirect_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       stall = 1'b0, br_taken = 1'b0, jal_ex = 1'b0, jalr_ex = 1'b0;
  logic       mret_ex = 1'b0, intr = 1'b0, mie = 1'b0;
  logic [2:0] pc_source;
  logic       pc_write, flush, int_taken, int_pend;

  typedef struct {
    logic [6:0] v;   // {src[2:0], wr, flush, int_taken, int_pend}
    string      nm;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  event mid_ev;

  pc_redirect_ctrl #(.FLUSH_CYCLES(2), .INT_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken),
    .jal_ex(jal_ex), .jalr_ex(jalr_ex), .mret_ex(mret_ex), .intr(intr),
    .mie(mie), .pc_source(pc_source), .pc_write(pc_write), .flush(flush),
    .int_taken(int_taken), .int_pend(int_pend)
  );

  always #5 clk = ~clk;

  // Monitor: compares DUT outputs against the oldest queued expectation.
  initial begin
    forever begin
      @(negedge clk or mid_ev);
      if (q.size() > 0) begin
        exp_t e;
        logic [6:0] act;
        e   = q.pop_front();
        act = {pc_source, pc_write, flush, int_taken, int_pend};
        n_checks++;
        if (act !== e.v) begin
          n_fail++;
          $display("FAIL %s: got src=%0d wr=%b flush=%b int_taken=%b int_pend=%b, want src=%0d wr=%b flush=%b int_taken=%b int_pend=%b",
                   e.nm, act[6:4], act[3], act[2], act[1], act[0],
                   e.v[6:4], e.v[3], e.v[2], e.v[1], e.v[0]);
        end else begin
          $display("check %s: src=%0d wr=%b flush=%b int_taken=%b int_pend=%b ok",
                   e.nm, act[6:4], act[3], act[2], act[1], act[0]);
        end
      end
    end
  end

  // One cycle of stimulus plus its expected outputs.
  task automatic step(input logic r, input logic st, input logic br, input logic jl,
                      input logic jr, input logic mr, input logic it, input logic me,
                      input logic [2:0] src, input logic wr, input logic fl,
                      input logic tk, input logic pd, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; stall = st; br_taken = br; jal_ex = jl; jalr_ex = jr;
    mret_ex = mr; intr = it; mie = me;
    e.v  = {src, wr, fl, tk, pd};
    e.nm = nm;
    q.push_back(e);
  endtask

  initial begin
    exp_t e;
    //    rst st br jl jr mr it me  src wr fl tk pd
    // Reset and idle
    step(1, 0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, "reset0");
    step(1, 0, 1, 1, 0, 0, 1, 1, 3'd0, 0, 0, 0, 0, "reset_inputs_hi");
    step(0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 1, 0, 0, 0, "idle0");
    step(0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 1, 0, 0, 0, "idle1");
    // Taken branch with two-cycle flush
    step(0, 0, 1, 0, 0, 0, 0, 0, 3'd2, 1, 1, 0, 0, "branch");
    step(0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 1, 1, 0, 0, "branch_flush");
    step(0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 1, 0, 0, 0, "branch_done");
    // Priority: JALR over BRANCH/JAL; branch in flushing cycle ignored
    step(0, 0, 1, 1, 1, 0, 0, 0, 3'd1, 1, 1, 0, 0, "jalr_prio");
    step(0, 0, 1, 0, 0, 0, 0, 0, 3'd0, 1, 1, 0, 0, "flush_ignore_br");
    step(0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 1, 0, 0, 0, "jalr_done");
    // MRET highest priority
    step(0, 0, 1, 1, 1, 1, 0, 0, 3'd5, 1, 1, 0, 0, "mret_prio");
    step(0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 1, 1, 0, 0, "mret_flush");
    step(0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 1, 0, 0, 0, "mret_done");
    // Interrupt held off by stall
    step(0, 1, 0, 0, 0, 0, 1, 1, 3'd0, 0, 0, 0, 0, "int_stall0");
    step(0, 1, 0, 0, 0, 0, 0, 1, 3'd0, 0, 0, 0, 1, "int_stall1");
    step(0, 1, 0, 0, 0, 0, 0, 1, 3'd0, 0, 0, 0, 1, "int_stall2");
    step(0, 0, 0, 0, 0, 0, 0, 1, 3'd4, 1, 1, 1, 1, "int_take");
    step(0, 0, 0, 0, 0, 0, 0, 1, 3'd0, 1, 1, 0, 0, "int_flush");
    step(0, 0, 0, 0, 0, 0, 0, 1, 3'd0, 1, 0, 0, 0, "int_done");
    // Interrupt coincident with branch: branch first, interrupt after flush
    step(0, 0, 1, 0, 0, 0, 1, 1, 3'd2, 1, 1, 0, 0, "br_with_intr");
    step(0, 0, 0, 0, 0, 0, 0, 1, 3'd0, 1, 1, 0, 1, "br_flush_pend");
    step(0, 0, 0, 0, 0, 0, 0, 1, 3'd4, 1, 1, 1, 1, "int_after_flush");
    step(0, 0, 0, 0, 0, 0, 0, 1, 3'd0, 1, 1, 0, 0, "int2_flush");
    step(0, 0, 0, 0, 0, 0, 0, 1, 3'd0, 1, 0, 0, 0, "int2_done");
    // MIE=0 holds the request; stall during flush drops WR
    step(0, 0, 0, 0, 0, 0, 1, 0, 3'd0, 1, 0, 0, 0, "mie0_req");
    step(0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 1, 0, 0, 1, "mie0_hold0");
    step(0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 1, 0, 0, 1, "mie0_hold1");
    step(0, 0, 0, 0, 0, 0, 0, 1, 3'd4, 1, 1, 1, 1, "mie1_take");
    step(0, 1, 0, 0, 0, 0, 0, 0, 3'd0, 0, 1, 0, 0, "flush_stalled");
    step(0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 1, 0, 0, 0, "mie_done");
    // Redirect overrides stall
    step(0, 1, 0, 1, 0, 0, 0, 0, 3'd3, 1, 1, 0, 0, "jal_over_stall");
    step(0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 1, 1, 0, 0, "jal_flush");
    step(0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 1, 0, 0, 0, "jal_done");
    // Async reset in the middle of FLUSHING
    step(0, 0, 0, 1, 0, 0, 1, 0, 3'd3, 1, 1, 0, 0, "jal_pre_rst");
    step(0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 1, 1, 0, 1, "flushing_pre_rst");
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    e.v  = 7'b0;
    e.nm = "mid_flush_rst";
    q.push_back(e);
    -> mid_ev;
    step(1, 0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, "rst_held");
    step(0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 1, 0, 0, 0, "post_rst0");
    step(0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 1, 0, 0, 0, "post_rst1");

    // Let the monitor drain the queue, bounded.
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
